signed_display_scanner: RTL and testbench
=========================================

// Module: signed_display_scanner
// PURPOSE
//  Drives a DIGITS-wide, time-multiplexed 7-segment display showing a signed binary value.
//  Converts the value to BCD serially, blanks leading zeros and places the minus sign left of the top digit.
//  Flags values that do not fit in the display.
//  Sits between the datapath (result register) and the board display pins; supersedes single-digit sign display.
// PARAMETERS
//  WIDTH     12    bit width of signed input value (two's complement), >=2
//  DIGITS    4     number of display positions, including the one used by the sign, >=2
//  SCAN_DIV  50000 clk cycles each digit stays enabled, >=1
// PORTS
//  clk      in   1      single system clock; all logic on rising edge
//  rst_n    in   1      synchronous, active-low reset
//  value    in   WIDTH  signed value to display
//  load     in   1      one-cycle strobe: capture value and start conversion
//  busy     out  1      conversion in progress; load ignored while high
//  ovf      out  1      displayed value does not fit in DIGITS positions
//  seg      out  7      segments {a,b,c,d,e,f,g}, active high; minus = 7'b0000001
//  an       out  DIGITS one-hot digit enable, active high, an[0] = rightmost digit
// BEHAVIOUR
//  Reset (rst_n=0 at edge): seg=0, an=0, busy=0, ovf=0, scan index=0, divider=0, shown buffer = +0.
//  Capture: load=1 && !busy -> latch sign and magnitude |value| (WIDTH bits unsigned; -2^(WIDTH-1) is exact); busy=1 next cycle.
//  Conversion: shift-add-3 double-dabble, one bit per cycle, WIDTH cycles; busy falls WIDTH+1 cycles after load edge.
//  Double buffering: previous value stays on display until conversion completes; BCD, sign, ovf update in one cycle with busy fall.
//  load while busy: ignored, no queueing. load in same cycle busy falls: ignored (busy still high).
//  Digit content for position i: BCD digit if i <= top nonzero index (digit 0 always shown, so 0 shows "0").
//  Sign position: position (top+1) shows minus when negative, blank otherwise; higher positions blank.
//  Negative zero is impossible; value 0 is never negative.
//  ovf=1 when digit count (+1 if negative) exceeds DIGITS; then every position shows minus, ovf held until next completed conversion.
//  Scan: divider counts 0..SCAN_DIV-1; at wrap, scan index advances i -> i+1, DIGITS-1 -> 0.
//  an = 1<<index, seg = pattern for index; both registered, change in same cycle (no ghost mix).
//  Digit patterns: 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000 8=1111111 9=1111011 blank=0000000.
//  Reset mid-conversion: conversion abandoned, buffer returns to +0, busy=0 next cycle.
// CONFIGURATION
//  SIGNED_DISPLAY_BLINK_EN defined: adds input port blink (1 bit); while blink=1, seg forced 0 during second half of
//   each 2*DIGITS*SCAN_DIV-cycle frame pair (alternating frames on/off), an keeps scanning; blink=0 -> normal.
//  Not defined: no blink port, no frame counter; behaviour exactly as above.
// STRUCTURE
//  Shared package: SEG_BLANK, SEG_MINUS, digit-to-segment function, BCD digit count ceil(WIDTH*log10 2)+1 as localparam function.
//  Sub-module bin2bcd_serial: start/done handshake, WIDTH-bit magnitude in, packed BCD out.
//  Top: capture/buffer registers, leading-zero/sign/ovf logic, scan divider and digit mux.
// TESTING (WIDTH=12, DIGITS=4, SCAN_DIV=4)
//  Reset held 3 cycles -> seg=0, an=0, busy=0; after release an=0001, seg=1111110 ("0"), other digits blank.
//  load value=-123 -> busy 13 cycles; scan shows an0 1111001, an1 1101101, an2 0110000, an3 0000001; ovf=0.
//  load value=5 -> an0 1011011, an1..an3 0000000; load value=2047 -> 2,0,4,7 shown, ovf=0.
//  load value=-2048 -> ovf=1, all four positions 0000001; then load 7 -> ovf=0.
//  load -1 then load 9 on 5th cycle of busy -> second ignored, display "-1" after completion.
//  rst_n=0 on 6th conversion cycle -> next cycle busy=0, display "0"; divider restarts at an=0001.
//  Blink build: blink=1 -> seg=0 for every cycle of odd frames, normal on even frames.

Source files
------------

// File: rtl/signed_display_scanner_pkg.sv
// rtl/signed_display_scanner_pkg.sv - shared segment constants and helpers for the signed display scanner
package signed_display_scanner_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_MINUS = 7'b0000001;

   // Segment order {a,b,c,d,e,f,g}, active high.
   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // ceil(width * log10(2)) + 1, with log10(2) approximated as 0.30103.
   function automatic int bcd_digits(input int width);
      return (width * 30103 + 99999) / 100000 + 1;
   endfunction

endpackage

// File: rtl/signed_display_scanner_if.sv
// rtl/signed_display_scanner_if.sv - value/load request and display outputs of the signed display scanner
interface signed_display_scanner_if #(
   parameter int WIDTH  = 12,
   parameter int DIGITS = 4
);
   logic [WIDTH-1:0]  value;
   logic              load;
   logic              busy;
   logic              ovf;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;

   modport master (output value, load, input busy, ovf, seg, an);
   modport slave  (input value, load, output busy, ovf, seg, an);
endinterface

// File: rtl/signed_display_scanner_bin2bcd_serial.sv
// rtl/signed_display_scanner_bin2bcd_serial.sv - serial shift-add-3 binary to packed BCD converter, one bit per cycle
module bin2bcd_serial #(
   parameter int WIDTH = 12,
   parameter int NDIG  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [WIDTH-1:0]  i_bin,
   output logic              o_done,
   output logic [4*NDIG-1:0] o_bcd
);
   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0]  r_sr;
   logic [4*NDIG-1:0] r_bcd;
   logic [4*NDIG-1:0] w_adj;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_active;
   logic              r_done;

   always_comb begin
      w_adj = r_bcd;
      for (int d = 0; d < NDIG; d++) begin
         if (r_bcd[4*d +: 4] >= 4'd5)
            w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sr     <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_sr     <= i_bin;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
         end else if (r_active) begin
            r_bcd <= {w_adj[4*NDIG-2:0], r_sr[WIDTH-1]};
            r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
            if (r_cnt == CNT_W'(WIDTH-1)) begin
               r_active <= 1'b0;
               r_done   <= 1'b1;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign o_done = r_done;
   assign o_bcd  = r_bcd;
endmodule

// File: rtl/signed_display_scanner.sv
// rtl/signed_display_scanner.sv - multiplexed signed 7-segment display driver; SIGNED_DISPLAY_BLINK_EN adds frame blinking
module signed_display_scanner
   import signed_display_scanner_pkg::*;
#(
   parameter int WIDTH    = 12,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input logic clk,
   input logic rst_n,
`ifdef SIGNED_DISPLAY_BLINK_EN
   input logic blink,
`endif
   signed_display_scanner_if.slave bus
);
   localparam int NDIG  = bcd_digits(WIDTH);
   localparam int BCD_W = 4 * NDIG;
   localparam int PADD  = (NDIG > DIGITS) ? NDIG : DIGITS;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = $clog2(DIGITS);

   logic              r_busy;
   logic              r_pend_neg;
   logic [BCD_W-1:0]  r_bcd;
   logic              r_neg;
   logic              r_ovf;
   logic [DIV_W-1:0]  r_div;
   logic [IDX_W-1:0]  r_idx;
   logic [DIGITS-1:0] r_an;
   logic [6:0]        r_seg;

   logic              w_start;
   logic [WIDTH-1:0]  w_mag;
   logic              w_done;
   logic [BCD_W-1:0]  w_conv;
   logic [BCD_W-1:0]  w_nbcd;
   logic [4*PADD-1:0] w_pad;
   logic              w_nneg;
   logic              w_novf;
   int                w_top;
   logic              w_wrap;
   logic [IDX_W-1:0]  w_idx_next;
   logic [6:0]        w_pat [DIGITS];

   assign w_start = bus.load && !r_busy;
   assign w_mag   = bus.value[WIDTH-1] ? (~bus.value + 1'b1) : bus.value;

   bin2bcd_serial #(.WIDTH(WIDTH), .NDIG(NDIG)) u_bin2bcd (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_start),
      .i_bin   (w_mag),
      .o_done  (w_done),
      .o_bcd   (w_conv)
   );

   // Next buffer contents: patterns are built from these so seg follows the commit edge directly.
   always_comb begin
      w_nbcd = w_done ? w_conv : r_bcd;
      w_nneg = w_done ? (r_pend_neg && (w_conv != '0)) : r_neg;
      w_pad  = '0;
      w_pad[BCD_W-1:0] = w_nbcd;
      w_top  = 0;
      for (int d = 0; d < NDIG; d++) begin
         if (w_nbcd[4*d +: 4] != 4'd0)
            w_top = d;
      end
      w_novf = w_done ? ((w_top + 1 + (w_nneg ? 1 : 0)) > DIGITS) : r_ovf;
      for (int p = 0; p < DIGITS; p++) begin
         w_pat[p] = SEG_BLANK;
         if (w_novf)
            w_pat[p] = SEG_MINUS;
         else if (p <= w_top)
            w_pat[p] = digit_to_seg(w_pad[4*p +: 4]);
         else if ((p == w_top + 1) && w_nneg)
            w_pat[p] = SEG_MINUS;
      end
   end

   always_comb begin
      w_wrap     = (r_div == DIV_W'(SCAN_DIV - 1));
      w_idx_next = r_idx;
      if (w_wrap)
         w_idx_next = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
   end

`ifdef SIGNED_DISPLAY_BLINK_EN
   // Toggles at each full scan of all positions; odd frames are dark while blinking.
   logic r_odd;
   logic w_odd_next;
   assign w_odd_next = r_odd ^ (w_wrap && (r_idx == IDX_W'(DIGITS - 1)));

   always_ff @(posedge clk) begin
      if (!rst_n) r_odd <= 1'b0;
      else        r_odd <= w_odd_next;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy     <= 1'b0;
         r_pend_neg <= 1'b0;
         r_bcd      <= '0;
         r_neg      <= 1'b0;
         r_ovf      <= 1'b0;
         r_div      <= '0;
         r_idx      <= '0;
         r_an       <= '0;
         r_seg      <= SEG_BLANK;
      end else begin
         if (w_start) begin
            r_busy     <= 1'b1;
            r_pend_neg <= bus.value[WIDTH-1];
         end else if (w_done) begin
            r_busy <= 1'b0;
         end
         r_bcd <= w_nbcd;
         r_neg <= w_nneg;
         r_ovf <= w_novf;
         r_div <= w_wrap ? '0 : r_div + 1'b1;
         r_idx <= w_idx_next;
         r_an  <= {{(DIGITS-1){1'b0}}, 1'b1} << w_idx_next;
`ifdef SIGNED_DISPLAY_BLINK_EN
         r_seg <= (blink && w_odd_next) ? SEG_BLANK : w_pat[w_idx_next];
`else
         r_seg <= w_pat[w_idx_next];
`endif
      end
   end

   assign bus.busy = r_busy;
   assign bus.ovf  = r_ovf;
   assign bus.seg  = r_seg;
   assign bus.an   = r_an;
endmodule

// File: tb/tb_signed_display_scanner.sv
// tb/tb_signed_display_scanner.sv - directed self-checking bench for signed_display_scanner
module tb_signed_display_scanner;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   signed_display_scanner_if #(.WIDTH(12), .DIGITS(4)) bus ();

`ifdef SIGNED_DISPLAY_BLINK_EN
   logic blink;
   signed_display_scanner #(.WIDTH(12), .DIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .blink(blink), .bus(bus));
`else
   signed_display_scanner #(.WIDTH(12), .DIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
   localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S7 = 7'b1110000, S8 = 7'b1111111;
   localparam logic [6:0] SB = 7'b0000000, SM = 7'b0000001;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Watches two full scans and records the pattern shown at each position.
   task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
      logic [6:0] seen [4];
      logic [3:0] got;
      got = 4'b0;
      for (int i = 0; i < 4; i++) seen[i] = 7'h7f;
      for (int k = 0; k < 32; k++) begin
         for (int p = 0; p < 4; p++) begin
            if (bus.an == (4'b0001 << p)) begin
               seen[p] = bus.seg;
               got[p]  = 1'b1;
            end
         end
         @(negedge clk);
      end
      chk({tag, "_an_all"}, got, 4'b1111);
      chk({tag, "_pos0"}, seen[0], e0);
      chk({tag, "_pos1"}, seen[1], e1);
      chk({tag, "_pos2"}, seen[2], e2);
      chk({tag, "_pos3"}, seen[3], e3);
   endtask

   // Loads v; optionally pokes a second load of v2 on busy cycle poke_at. Returns busy-high cycles seen.
   task automatic load_value(input logic [11:0] v, input int poke_at, input logic [11:0] v2, output int n);
      bus.value = v;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      n = 0;
      while (bus.busy && n < 40) begin
         n++;
         if (n == poke_at) begin
            bus.value = v2;
            bus.load  = 1'b1;
         end else begin
            bus.load = 1'b0;
         end
         @(negedge clk);
      end
      bus.load = 1'b0;
   endtask

   initial begin
      int n;
      int z0, z1;
      logic [3:0] prev_an;
      rst_n     = 1'b0;
      bus.load  = 1'b0;
      bus.value = '0;
`ifdef SIGNED_DISPLAY_BLINK_EN
      blink = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_seg", bus.seg, SB);
      chk("rst_an", bus.an, 4'b0000);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_ovf", bus.ovf, 1'b0);

      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_an", bus.an, 4'b0001);
      chk("rel_seg", bus.seg, S0);
      scan_check("zero", S0, SB, SB, SB);

      load_value(12'hF85, 0, 12'h000, n);              // -123
      chk("m123_busy", n, 13);
      chk("m123_ovf", bus.ovf, 1'b0);
      scan_check("m123", S3, S2, S1, SM);

      load_value(12'd5, 0, 12'h000, n);
      chk("p5_busy", n, 13);
      scan_check("p5", S5, SB, SB, SB);

      load_value(12'd2047, 0, 12'h000, n);
      chk("p2047_ovf", bus.ovf, 1'b0);
      scan_check("p2047", S7, S4, S0, S2);

      load_value(12'h800, 0, 12'h000, n);              // -2048
      chk("m2048_ovf", bus.ovf, 1'b1);
      scan_check("m2048", SM, SM, SM, SM);

`ifdef SIGNED_DISPLAY_BLINK_EN
      blink   = 1'b1;
      prev_an = bus.an;
      @(negedge clk);
      n = 0;
      while (!(bus.an == 4'b0001 && prev_an == 4'b1000) && n < 40) begin
         prev_an = bus.an;
         @(negedge clk);
         n++;
      end
      chk("blink_sync", (n < 40), 1'b1);
      z0 = 0;
      z1 = 0;
      for (int k = 0; k < 32; k++) begin
         if (bus.seg == SB) begin
            if (k < 16) z0++;
            else        z1++;
         end
         @(negedge clk);
      end
      chk("blink_frames", ((z0 == 16 && z1 == 0) || (z0 == 0 && z1 == 16)), 1'b1);
      blink = 1'b0;
      scan_check("blink_off", SM, SM, SM, SM);
`endif

      load_value(12'd7, 0, 12'h000, n);
      chk("p7_ovf", bus.ovf, 1'b0);
      scan_check("p7", S7, SB, SB, SB);

      load_value(12'hFFF, 4, 12'd9, n);                // -1, then 9 while busy
      chk("m1_busy", n, 13);
      chk("m1_ovf", bus.ovf, 1'b0);
      scan_check("m1", S1, SM, SB, SB);

      // load presented exactly on the edge where busy falls must be dropped
      bus.value = 12'd8;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (12) @(negedge clk);
      chk("fall_busy_pre", bus.busy, 1'b1);
      bus.value = 12'd6;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      chk("fall_busy_post", bus.busy, 1'b0);
      @(negedge clk);
      chk("fall_busy_stay", bus.busy, 1'b0);
      scan_check("p8", S8, SB, SB, SB);

      // reset during conversion
      bus.value = 12'd456;
      bus.load  = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", bus.busy, 1'b0);
      chk("mid_rst_an", bus.an, 4'b0000);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_an", bus.an, 4'b0001);
      chk("mid_rel_seg", bus.seg, S0);
      chk("mid_rel_ovf", bus.ovf, 1'b0);
      scan_check("mid_zero", S0, SB, SB, SB);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
